// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: turns a core memory request into one valid/ready
// bus transaction and stalls the core until the access has completed.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  mask_type,
    input  logic        ext_type,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_error,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] MT_BYTE = 2'b00;
    localparam logic [1:0] MT_HALF = 2'b01;
    localparam logic [1:0] MT_WORD = 2'b10;

    state_t           state_p0;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_p0;
    logic             timeout_hit;
    logic [1:0]       mask_in;
    logic             misaligned_req;

    logic             we_p0;
    logic [31:2]      waddr_p0;
    logic [1:0]       lane_p0;
    logic [1:0]       mask_p0;
    logic             ext_p0;
    logic [3:0]       be_p0;
    logic [31:0]      wdata_p0;

    logic [31:0]      rdata_p1;
    logic             mis_p1;
    logic             berr_p1;

    function automatic logic is_misaligned(input logic [1:0] mask, input logic [1:0] lane);
        case (mask)
            MT_BYTE: return 1'b0;
            MT_HALF: return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] be_gen(input logic [1:0] mask, input logic [1:0] lane);
        case (mask)
            MT_BYTE: return 4'b0001 << lane;
            MT_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_gen(input logic [1:0] mask, input logic [31:0] wd);
        case (mask)
            MT_BYTE: return {4{wd[7:0]}};
            MT_HALF: return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0]  mask,
                                                 input logic        ext,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (mask)
            MT_BYTE: return ext ? {24'b0, b} : {{24{b[7]}}, b};
            MT_HALF: return ext ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Encoding 11 behaves exactly like a word access.
    assign mask_in        = (mask_type == 2'b11) ? MT_WORD : mask_type;
    assign misaligned_req = is_misaligned(mask_in, req_addr[1:0]);
    assign timeout_hit    = (TIMEOUT_CYCLES != 0) && (cnt_p0 == CNT_LAST);

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE: if (req_valid) state_nxt = misaligned_req ? DONE : REQ;
            REQ: begin
                if (bus_ready)        state_nxt = we_p0 ? DONE : RESP;
                else if (timeout_hit) state_nxt = DONE;
            end
            RESP: if (bus_rvalid || timeout_hit) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: control state, timeout counter and completion flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
            cnt_p0   <= '0;
            mis_p1   <= 1'b0;
            berr_p1  <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            if (state_nxt != state_p0)
                cnt_p0 <= '0;
            else if (state_p0 == REQ || state_p0 == RESP)
                cnt_p0 <= cnt_p0 + 1'b1;
            case (state_p0)
                IDLE: if (req_valid) begin
                    mis_p1  <= misaligned_req;
                    berr_p1 <= 1'b0;
                end
                REQ:  if (!bus_ready && timeout_hit)  berr_p1 <= 1'b1;
                RESP: if (!bus_rvalid && timeout_hit) berr_p1 <= 1'b1;
                DONE: begin
                    mis_p1  <= 1'b0;
                    berr_p1 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Stage p0 data capture and p1 load result; data regs need no reset because
    // every output that exposes them is gated by state.
    always_ff @(posedge clk) begin
        if (state_p0 == IDLE && req_valid) begin
            we_p0    <= req_we;
            waddr_p0 <= req_addr[31:2];
            lane_p0  <= req_addr[1:0];
            mask_p0  <= mask_in;
            ext_p0   <= ext_type;
            be_p0    <= be_gen(mask_in, req_addr[1:0]);
            wdata_p0 <= wdata_gen(mask_in, req_wdata);
            rdata_p1 <= '0;
        end else if (state_p0 == RESP && bus_rvalid) begin
            rdata_p1 <= load_extract(mask_p0, ext_p0, lane_p0, bus_rdata);
        end
    end

    assign stall      = !rst && ((state_p0 == IDLE && req_valid) ||
                                 state_p0 == REQ || state_p0 == RESP);
    assign bus_valid  = (state_p0 == REQ);
    assign bus_we     = bus_valid && we_p0;
    assign bus_addr   = bus_valid ? {waddr_p0, 2'b00} : 32'h0;
    assign bus_be     = bus_valid ? be_p0 : 4'h0;
    assign bus_wdata  = bus_valid ? wdata_p0 : 32'h0;
    assign rdata      = (state_p0 == DONE) ? rdata_p1 : 32'h0;
    assign misaligned = (state_p0 == DONE) && mis_p1;
    assign bus_error  = (state_p0 == DONE) && berr_p1;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected bus handshakes
// and completions, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, to_req_valid, req_we, ext_type;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  mask_type;
    logic        bus_ready, bus_rvalid;
    logic [31:0] bus_rdata;

    logic        a_stall, a_mis, a_berr, a_bv, a_bwe;
    logic [31:0] a_rdata, a_baddr, a_bwdata;
    logic [3:0]  a_bbe;
    logic        b_stall, b_mis, b_berr, b_bv, b_bwe;
    logic [31:0] b_rdata, b_baddr, b_bwdata;
    logic [3:0]  b_bbe;

    always #5 clk = ~clk;

    load_store_unit u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .mask_type(mask_type),
        .ext_type(ext_type), .stall(a_stall), .rdata(a_rdata),
        .misaligned(a_mis), .bus_error(a_berr), .bus_valid(a_bv),
        .bus_ready(bus_ready), .bus_we(a_bwe), .bus_addr(a_baddr),
        .bus_be(a_bbe), .bus_wdata(a_bwdata), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    load_store_unit #(.TIMEOUT_CYCLES(4)) u_to (
        .clk(clk), .rst(rst), .req_valid(to_req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .mask_type(mask_type),
        .ext_type(ext_type), .stall(b_stall), .rdata(b_rdata),
        .misaligned(b_mis), .bus_error(b_berr), .bus_valid(b_bv),
        .bus_ready(bus_ready), .bus_we(b_bwe), .bus_addr(b_baddr),
        .bus_be(b_bbe), .bus_wdata(b_bwdata), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    // sel picks which instance the responder and monitor observe
    logic        sel;
    logic        m_stall, m_mis, m_berr, m_bv, m_bwe;
    logic [31:0] m_rdata, m_baddr, m_bwdata;
    logic [3:0]  m_bbe;
    assign m_stall  = sel ? b_stall  : a_stall;
    assign m_mis    = sel ? b_mis    : a_mis;
    assign m_berr   = sel ? b_berr   : a_berr;
    assign m_bv     = sel ? b_bv     : a_bv;
    assign m_bwe    = sel ? b_bwe    : a_bwe;
    assign m_rdata  = sel ? b_rdata  : a_rdata;
    assign m_baddr  = sel ? b_baddr  : a_baddr;
    assign m_bwdata = sel ? b_bwdata : a_bwdata;
    assign m_bbe    = sel ? b_bbe    : a_bbe;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          vcyc;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
        int          scyc;
    } done_exp_t;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];
    int checks = 0;
    int errors = 0;

    int          ready_dly = 0;
    bit          rdy_en = 1'b1;
    int          rv_dly = 0;
    bit          rv_en = 1'b1;
    logic [31:0] resp_word = 32'h0;
    bit          rd_pending = 1'b0;
    bit          force_rvalid = 1'b0;
    int          rv_cnt = 0;
    int          v_cnt = 0;

    task automatic exp_bus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata, input int vcyc);
        bus_exp_t e;
        e.addr = addr; e.we = we; e.be = be; e.wdata = wdata; e.vcyc = vcyc;
        bus_q.push_back(e);
    endtask

    task automatic exp_done(input logic [31:0] rd, input logic mis, input logic berr, input int scyc);
        done_exp_t e;
        e.rdata = rd; e.mis = mis; e.berr = berr; e.scyc = scyc;
        done_q.push_back(e);
    endtask

    // Bus responder: ready after ready_dly waiting cycles, read data rv_dly cycles after that
    initial begin
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            bus_ready  = 1'b0;
            bus_rvalid = force_rvalid;
            if (rd_pending) begin
                if (rv_en && rv_cnt == rv_dly) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = resp_word;
                    rd_pending = 1'b0;
                end else begin
                    rv_cnt++;
                end
            end
            if (m_bv) begin
                if (rdy_en && v_cnt == ready_dly) begin
                    bus_ready = 1'b1;
                    v_cnt = 0;
                    if (!m_bwe) begin
                        rd_pending = 1'b1;
                        rv_cnt = 0;
                    end
                end else begin
                    v_cnt++;
                end
            end else begin
                v_cnt = 0;
            end
        end
    end

    int stall_cnt = 0;
    int vcyc = 0;
    int bv_total = 0;

    // Monitor: handshakes and completions are checked against the queues
    always @(negedge clk) begin
        bus_exp_t  be_e;
        done_exp_t de;
        if (rst) begin
            stall_cnt = 0;
            vcyc = 0;
        end else begin
            if (m_bv) begin
                vcyc++;
                bv_total++;
            end
            if (m_bv && bus_ready) begin
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: addr=%h we=%b be=%b", m_baddr, m_bwe, m_bbe);
                end else begin
                    be_e = bus_q.pop_front();
                    if (m_baddr !== be_e.addr || m_bwe !== be_e.we || m_bbe !== be_e.be ||
                        m_bwdata !== be_e.wdata || vcyc != be_e.vcyc) begin
                        errors++;
                        $display("FAIL bus_req: got addr=%h we=%b be=%b wdata=%h vcyc=%0d, want addr=%h we=%b be=%b wdata=%h vcyc=%0d",
                                 m_baddr, m_bwe, m_bbe, m_bwdata, vcyc,
                                 be_e.addr, be_e.we, be_e.be, be_e.wdata, be_e.vcyc);
                    end
                end
            end
            if (!m_bv) vcyc = 0;

            if (m_stall) begin
                stall_cnt++;
            end
            if (!m_stall && stall_cnt > 0) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: rdata=%h mis=%b berr=%b", m_rdata, m_mis, m_berr);
                end else begin
                    de = done_q.pop_front();
                    if (m_rdata !== de.rdata || m_mis !== de.mis || m_berr !== de.berr ||
                        stall_cnt != de.scyc) begin
                        errors++;
                        $display("FAIL done: got rdata=%h mis=%b berr=%b stall=%0d, want rdata=%h mis=%b berr=%b stall=%0d",
                                 m_rdata, m_mis, m_berr, stall_cnt, de.rdata, de.mis, de.berr, de.scyc);
                    end
                end
                stall_cnt = 0;
            end else begin
                checks++;
                if (m_rdata !== 32'h0 || m_mis !== 1'b0 || m_berr !== 1'b0) begin
                    errors++;
                    $display("FAIL outputs_outside_done: rdata=%h mis=%b berr=%b, want 0", m_rdata, m_mis, m_berr);
                end
            end
        end
    end

    // Issue one request and hold it until the completion cycle, bounded
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] mt, input logic ext);
        bit seen;
        seen = 1'b0;
        req_we = we; req_addr = addr; req_wdata = wdata; mask_type = mt; ext_type = ext;
        if (sel) to_req_valid = 1'b1;
        else     req_valid = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (!m_stall) seen = 1'b1;
        end
        req_valid = 1'b0;
        to_req_valid = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_wait: addr=%h never completed within 40 cycles", addr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({a_stall, a_bv, a_bwe, a_baddr, a_bbe, a_bwdata, a_rdata, a_mis, a_berr} !== '0) begin
            errors++;
            $display("FAIL %s: stall=%b bv=%b we=%b addr=%h be=%b wdata=%h rdata=%h mis=%b berr=%b, want all 0",
                     name, a_stall, a_bv, a_bwe, a_baddr, a_bbe, a_bwdata, a_rdata, a_mis, a_berr);
        end
    endtask

    initial begin
        int bv_before;
        sel = 1'b0;
        rst = 1'b1;
        req_valid = 1'b1;
        to_req_valid = 1'b0;
        req_we = 1'b0; req_addr = 32'h100; req_wdata = 32'h0; mask_type = 2'b10; ext_type = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset_state");
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        resp_word = 32'hA1B2C3D4;
        exp_bus(32'h100, 1'b0, 4'b1111, 32'h0, 1);
        exp_done(32'hA1B2C3D4, 1'b0, 1'b0, 3);
        run_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0);

        resp_word = 32'h80FFFFFF;
        exp_bus(32'h100, 1'b0, 4'b1000, 32'h0, 1);
        exp_done(32'hFFFFFF80, 1'b0, 1'b0, 3);
        run_req(1'b0, 32'h103, 32'h0, 2'b00, 1'b0);
        exp_bus(32'h100, 1'b0, 4'b1000, 32'h0, 1);
        exp_done(32'h00000080, 1'b0, 1'b0, 3);
        run_req(1'b0, 32'h103, 32'h0, 2'b00, 1'b1);

        ready_dly = 4;
        exp_bus(32'h200, 1'b1, 4'b1100, 32'hBEEFBEEF, 5);
        exp_done(32'h0, 1'b0, 1'b0, 6);
        run_req(1'b1, 32'h202, 32'h1234BEEF, 2'b01, 1'b0);
        ready_dly = 0;

        bv_before = bv_total;
        exp_done(32'h0, 1'b1, 1'b0, 1);
        run_req(1'b0, 32'h101, 32'h0, 2'b10, 1'b0);
        exp_done(32'h0, 1'b1, 1'b0, 1);
        run_req(1'b1, 32'h102, 32'hDEADBEEF, 2'b10, 1'b0);
        exp_done(32'h0, 1'b1, 1'b0, 1);
        run_req(1'b0, 32'h101, 32'h0, 2'b01, 1'b0);
        checks++;
        if (bv_total != bv_before) begin
            errors++;
            $display("FAIL misaligned_bus: bus_valid cycles=%0d, want 0", bv_total - bv_before);
        end

        resp_word = 32'h80011234;
        exp_bus(32'h100, 1'b0, 4'b1100, 32'h0, 1);
        exp_done(32'hFFFF8001, 1'b0, 1'b0, 3);
        run_req(1'b0, 32'h102, 32'h0, 2'b01, 1'b0);
        resp_word = 32'h8001F234;
        exp_bus(32'h100, 1'b0, 4'b0011, 32'h0, 1);
        exp_done(32'h0000F234, 1'b0, 1'b0, 3);
        run_req(1'b0, 32'h100, 32'h0, 2'b01, 1'b1);
        exp_bus(32'h100, 1'b1, 4'b0010, 32'hA5A5A5A5, 1);
        exp_done(32'h0, 1'b0, 1'b0, 2);
        run_req(1'b1, 32'h101, 32'h000000A5, 2'b00, 1'b0);
        exp_bus(32'h104, 1'b1, 4'b1111, 32'hCAFEF00D, 1);
        exp_done(32'h0, 1'b0, 1'b0, 2);
        run_req(1'b1, 32'h104, 32'hCAFEF00D, 2'b10, 1'b0);
        resp_word = 32'h11227F33;
        exp_bus(32'h100, 1'b0, 4'b0010, 32'h0, 1);
        exp_done(32'h0000007F, 1'b0, 1'b0, 3);
        run_req(1'b0, 32'h101, 32'h0, 2'b00, 1'b0);
        rv_dly = 2;
        resp_word = 32'h76543210;
        exp_bus(32'h108, 1'b0, 4'b1111, 32'h0, 1);
        exp_done(32'h76543210, 1'b0, 1'b0, 5);
        run_req(1'b0, 32'h108, 32'h0, 2'b11, 1'b1);
        rv_dly = 0;

        // Timeout instance: response never arrives, then ready never arrives
        sel = 1'b1;
        rv_en = 1'b0;
        exp_bus(32'h300, 1'b0, 4'b1111, 32'h0, 1);
        exp_done(32'h0, 1'b0, 1'b1, 6);
        run_req(1'b0, 32'h300, 32'h0, 2'b10, 1'b0);
        rd_pending = 1'b0;
        rdy_en = 1'b0;
        exp_done(32'h0, 1'b0, 1'b1, 5);
        run_req(1'b0, 32'h304, 32'h0, 2'b10, 1'b0);
        rdy_en = 1'b1;
        sel = 1'b0;

        // Reset while waiting in RESP, then a late rvalid
        exp_bus(32'h400, 1'b0, 4'b1111, 32'h0, 1);
        req_we = 1'b0; req_addr = 32'h400; req_wdata = 32'h0; mask_type = 2'b10; ext_type = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (a_stall !== 1'b1) begin
            errors++;
            $display("FAIL resp_stall: stall=%b, want 1", a_stall);
        end
        rst = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rd_pending = 1'b0;
        force_rvalid = 1'b1;
        resp_word = 32'h5555AAAA;
        bus_rdata = 32'h5555AAAA;
        check_quiet("reset_mid_resp");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_quiet("late_rvalid_ignored");
        force_rvalid = 1'b0;
        rv_en = 1'b1;
        @(posedge clk);
        #1;
        check_quiet("idle_after_reset");

        resp_word = 32'h0BADF00D;
        exp_bus(32'h404, 1'b0, 4'b1111, 32'h0, 1);
        exp_done(32'h0BADF00D, 1'b0, 1'b0, 3);
        run_req(1'b0, 32'h404, 32'h0, 2'b10, 1'b0);

        repeat (2) @(posedge clk);
        checks++;
        if (bus_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: bus=%0d done=%0d, want 0 0", bus_q.size(), done_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
